tnet_tx_arb: RTL and testbench
==============================

TNET_TX_ARB -- requirements
Module: tnet_tx_arb

Interface
REQ-001 SHALL have parameter KA_PERIOD, default 1024: idle cycles before a keep-alive beat is emitted; 0 disables keep-alive.
REQ-002 SHALL have parameter MAX_BURST, default 4: maximum consecutive propagate grants while a local request waits; range 1..15.
REQ-003 SHALL have one clock; reset is asynchronous and active-high. Ports: user_clk_i  in  1  clock; user_rst_i  in  1  async active-high reset.
REQ-004 SHALL have port channel_ok_i  in  1  Aurora channel up.
REQ-005 SHALL have port ID  in  8  node ID.
REQ-006 SHALL have port prop_req_i  in  1  propagate beat pending (level).
REQ-007 SHALL have port prop_dt_i  in  128  propagate beat.
REQ-008 SHALL have port prop_ack_o  out  1  one-cycle pulse when the propagate beat is accepted by the link.
REQ-009 SHALL have port loc_req_i  in  1  local transmit pending (level).
REQ-010 SHALL have port loc_dt_i  in  128  local beat.
REQ-011 SHALL have port loc_ack_o  out  1  one-cycle pulse when the local beat is accepted.
REQ-012 SHALL have ports m_axi_tx_tdata_o  out  128; m_axi_tx_tvalid_o  out  1; m_axi_tx_tready_i  in  1  (AXI-Stream TX to channel B).
REQ-013 SHALL have port ready_o  out  1  arbiter out of NOT_READY.
REQ-014 SHALL have port pkt_cnt_o  out  32  beats accepted by the link.

Function
REQ-015 SHALL implement FSM states NOT_READY, IDLE, XFER.
REQ-016 NOT_READY: ready_o=0, no grants; go to IDLE when channel_ok_i=1.
REQ-017 IDLE: if channel_ok_i=0, go to NOT_READY; else choose a winner, register its data into m_axi_tx_tdata_o and the winner tag (PROP/LOC/KA), set tvalid, and go to XFER. Latency is req sampled in cycle N -> tvalid=1 in cycle N+1.
REQ-018 Priority SHALL be PROP over LOC, except LOC wins when loc_req_i=1 and streak==MAX_BURST; KA wins only when neither req is asserted.
REQ-019 The 4-bit streak counter SHALL increment on each PROP grant made while loc_req_i=1, clear on any LOC grant, and clear when loc_req_i=0 in IDLE.
REQ-020 XFER: tvalid and tdata SHALL be held stable until m_axi_tx_tready_i=1. On that cycle, the winner's ack pulses (combinational tvalid&tready&tag) and pkt_cnt_o increments, wrapping 2^32-1 -> 0. Next state is IDLE; one bubble cycle per beat is accepted.
REQ-021 A channel_ok_i drop during XFER SHALL NOT drop tvalid; complete the beat, then IDLE -> NOT_READY.
REQ-022 The idle counter SHALL count IDLE cycles with no req asserted. When it equals KA_PERIOD-1 and both reqs are low, KA is granted. The counter clears on any grant and whenever a req is asserted.
REQ-023 A request arriving in the same cycle as KA expiry SHALL win, with no KA grant.
REQ-024 KA beat: [127:120]=8'hF0, [119]=0, [118:114]=0, [113:105]={1'b0,ID}, [104:32]=0, [31:0]=16-bit KA sequence zero-extended.
REQ-025 The KA sequence SHALL increment on each KA accept and wrap at 16'hFFFF.
REQ-026 The requester data SHALL be sampled only at grant; changes on *_dt_i during XFER SHALL be ignored.
REQ-027 Acks SHALL never assert in NOT_READY or IDLE, and never both in the same cycle.

Reset
REQ-028 user_rst_i asserted SHALL immediately (asynchronously) force: state NOT_READY, m_axi_tx_tvalid_o=0, m_axi_tx_tdata_o=0, prop_ack_o=0, loc_ack_o=0, ready_o=0, pkt_cnt_o=0, streak=0, idle counter=0, KA sequence=0.
REQ-029 Reset asserted mid-XFER SHALL abandon the beat with no ack; after release, arbitration restarts from NOT_READY.

Verification
REQ-030 Both reqs held high, tready=1, MAX_BURST=4 -> grant order P,P,P,P,L,P,P,P,P,L; pkt_cnt_o=10 after 10 beats.
REQ-031 loc_req_i=1 with data 128'h1234, tready low 5 cycles -> tvalid high 5+ cycles, tdata stable =128'h1234, loc_ack_o single pulse on the tready cycle.
REQ-032 KA_PERIOD=8, ID=8'h05, no reqs -> KA beat 9 cycles after IDLE entry with tdata[127:120]=F0, [113:105]=9'h005, [31:0]=0; next KA has [31:0]=1.
REQ-033 prop_req_i rises in the cycle the idle counter hits KA_PERIOD-1 -> PROP granted, no KA, idle counter=0.
REQ-034 channel_ok_i drops while in XFER with tready=0 -> tvalid held; after tready, ack pulses, then NOT_READY with ready_o=0.
REQ-035 user_rst_i pulsed mid-XFER -> tvalid=0 in the same cycle, no ack, pkt_cnt_o=0; resumes after channel_ok_i=1.

Source files
------------

// File: rtl/tnet_tx_arb.sv
// Link TX arbiter: propagate/local/keep-alive beats onto one AXI-Stream channel.
// One beat in flight; grant-to-tvalid is one cycle, with one IDLE bubble per beat.
module tnet_tx_arb #(
  parameter int KA_PERIOD = 1024,
  parameter int MAX_BURST = 4
) (
  input  logic         user_clk_i,
  input  logic         user_rst_i,
  input  logic         channel_ok_i,
  input  logic [7:0]   ID,
  input  logic         prop_req_i,
  input  logic [127:0] prop_dt_i,
  output logic         prop_ack_o,
  input  logic         loc_req_i,
  input  logic [127:0] loc_dt_i,
  output logic         loc_ack_o,
  output logic [127:0] m_axi_tx_tdata_o,
  output logic         m_axi_tx_tvalid_o,
  input  logic         m_axi_tx_tready_i,
  output logic         ready_o,
  output logic [31:0]  pkt_cnt_o
);

  localparam int KA_LAST = (KA_PERIOD > 0) ? KA_PERIOD - 1 : 0;
  localparam int CW      = (KA_LAST > 0) ? $clog2(KA_LAST + 1) : 1;
  localparam logic [CW-1:0] KA_LAST_C = CW'(KA_LAST);
  localparam logic [3:0]    BURST_C   = 4'(MAX_BURST);

  typedef enum logic [1:0] {NOT_READY, IDLE, XFER} state_t;
  typedef enum logic [1:0] {TAG_PROP, TAG_LOC, TAG_KA} tag_t;

  state_t          r_state;
  state_t          w_next;
  tag_t            r_tag;
  logic [127:0]    r_tdata;
  logic [3:0]      r_streak;
  logic [CW-1:0]   r_idle_cnt;
  logic [15:0]     r_ka_seq;
  logic [31:0]     r_pkt_cnt;

  logic            w_grant_prop;
  logic            w_grant_loc;
  logic            w_grant_ka;
  logic            w_grant;
  logic            w_accept;
  logic            w_no_req;
  logic [127:0]    w_ka_beat;

  assign w_no_req  = !prop_req_i && !loc_req_i;
  assign w_grant   = w_grant_prop || w_grant_loc || w_grant_ka;
  assign w_ka_beat = {8'hF0, 1'b0, 5'd0, 1'b0, ID, 73'd0, 16'd0, r_ka_seq};

  always_ff @(posedge user_clk_i or posedge user_rst_i) begin
    if (user_rst_i) r_state <= NOT_READY;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_grant_prop = 1'b0;
    w_grant_loc  = 1'b0;
    w_grant_ka   = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      NOT_READY: if (channel_ok_i) w_next = IDLE;
      IDLE: begin
        if (!channel_ok_i) begin
          w_next = NOT_READY;
        end else begin
          // Local traffic only jumps the queue once propagate has had its burst.
          if (loc_req_i && (!prop_req_i || r_streak == BURST_C)) w_grant_loc = 1'b1;
          else if (prop_req_i)                                  w_grant_prop = 1'b1;
          else if (KA_PERIOD != 0 && r_idle_cnt == KA_LAST_C)   w_grant_ka = 1'b1;
          if (w_grant_prop || w_grant_loc || w_grant_ka) w_next = XFER;
        end
      end
      XFER: begin
        if (m_axi_tx_tready_i) begin
          w_accept = 1'b1;
          w_next   = IDLE;
        end
      end
      default: w_next = NOT_READY;
    endcase
  end

  always_ff @(posedge user_clk_i or posedge user_rst_i) begin
    if (user_rst_i) begin
      r_tag      <= TAG_PROP;
      r_tdata    <= 128'd0;
      r_streak   <= 4'd0;
      r_idle_cnt <= '0;
      r_ka_seq   <= 16'd0;
      r_pkt_cnt  <= 32'd0;
    end else begin
      if (w_grant) begin
        if (w_grant_prop) begin
          r_tdata <= prop_dt_i;
          r_tag   <= TAG_PROP;
        end else if (w_grant_loc) begin
          r_tdata <= loc_dt_i;
          r_tag   <= TAG_LOC;
        end else begin
          r_tdata <= w_ka_beat;
          r_tag   <= TAG_KA;
        end
      end

      if (r_state == IDLE) begin
        if (w_grant_loc || !loc_req_i) r_streak <= 4'd0;
        else if (w_grant_prop)         r_streak <= r_streak + 4'd1;
      end

      // Idle time only accumulates while the link is up and nobody is asking.
      if (KA_PERIOD != 0 && r_state == IDLE && channel_ok_i && w_no_req && !w_grant)
        r_idle_cnt <= r_idle_cnt + CW'(1);
      else
        r_idle_cnt <= '0;

      if (w_accept) begin
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
        if (r_tag == TAG_KA) r_ka_seq <= r_ka_seq + 16'd1;
      end
    end
  end

  assign m_axi_tx_tvalid_o = (r_state == XFER);
  assign m_axi_tx_tdata_o  = r_tdata;
  assign ready_o           = (r_state != NOT_READY);
  assign pkt_cnt_o         = r_pkt_cnt;
  assign prop_ack_o        = w_accept && (r_tag == TAG_PROP);
  assign loc_ack_o         = w_accept && (r_tag == TAG_LOC);

endmodule

// File: tb/tb_tnet_tx_arb.sv
// Directed bench for tnet_tx_arb with KA_PERIOD=8, MAX_BURST=4.
module tb_tnet_tx_arb;

  logic         clk;
  logic         rst;
  logic         ch_ok;
  logic [7:0]   id;
  logic         prop_req;
  logic [127:0] prop_dt;
  logic         prop_ack;
  logic         loc_req;
  logic [127:0] loc_dt;
  logic         loc_ack;
  logic [127:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         rdy;
  logic [31:0]  pkt_cnt;

  int total = 0;
  int bad   = 0;

  tnet_tx_arb #(.KA_PERIOD(8), .MAX_BURST(4)) dut (
    .user_clk_i        (clk),
    .user_rst_i        (rst),
    .channel_ok_i      (ch_ok),
    .ID                (id),
    .prop_req_i        (prop_req),
    .prop_dt_i         (prop_dt),
    .prop_ack_o        (prop_ack),
    .loc_req_i         (loc_req),
    .loc_dt_i          (loc_dt),
    .loc_ack_o         (loc_ack),
    .m_axi_tx_tdata_o  (tdata),
    .m_axi_tx_tvalid_o (tvalid),
    .m_axi_tx_tready_i (tready),
    .ready_o           (rdy),
    .pkt_cnt_o         (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; ch_ok = 1'b0; prop_req = 1'b0; loc_req = 1'b0;
    tready = 1'b0; prop_dt = '0; loc_dt = '0; id = 8'h05;
    repeat (2) tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; ch_ok = 1'b1; prop_req = 1'b1; loc_req = 1'b1;
    tready = 1'b1; prop_dt = 128'h77; loc_dt = 128'h88; id = 8'h05;
    repeat (3) tick;
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", tvalid); end
    total++; if (tdata !== 128'd0) begin bad++; $display("FAIL reset_tdata got=%h want=0", tdata); end
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", rdy); end
    total++; if (pkt_cnt !== 32'd0) begin bad++; $display("FAIL reset_pkt got=%0d want=0", pkt_cnt); end
    total++; if (prop_ack !== 1'b0 || loc_ack !== 1'b0) begin bad++; $display("FAIL reset_acks got=%b%b want=00", prop_ack, loc_ack); end
    do_reset;
    tick;
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL notready_hold got=%b want=0", rdy); end
  endtask

  task automatic test_burst;
    string got;
    int    n;
    int    cnt;
    bit    both;
    bit    dbad;
    do_reset;
    prop_dt = 128'hAAAA; loc_dt = 128'hBBBB;
    prop_req = 1'b1; loc_req = 1'b1; tready = 1'b1; ch_ok = 1'b1;
    got = ""; n = 0; cnt = 0; both = 0; dbad = 0;
    while (cnt < 10 && n < 100) begin
      tick; n++;
      if (prop_ack && loc_ack) both = 1;
      if (prop_ack) begin got = {got, "P"}; cnt++; if (tdata !== 128'hAAAA) dbad = 1; end
      else if (loc_ack) begin got = {got, "L"}; cnt++; if (tdata !== 128'hBBBB) dbad = 1; end
      if (cnt == 10) begin prop_req = 1'b0; loc_req = 1'b0; end
    end
    total++; if (got != "PPPPLPPPPL") begin bad++; $display("FAIL burst_order got=%s want=PPPPLPPPPL", got); end
    total++; if (both) begin bad++; $display("FAIL burst_dual_ack got=1 want=0"); end
    total++; if (dbad) begin bad++; $display("FAIL burst_data got=bad want=matching"); end
    tick;
    total++; if (pkt_cnt !== 32'd10) begin bad++; $display("FAIL burst_pkt got=%0d want=10", pkt_cnt); end
    tick;
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL burst_quiet got=%b want=0", tvalid); end
  endtask

  task automatic test_loc_hold;
    int  n;
    bit  hbad;
    do_reset;
    loc_dt = 128'h1234; loc_req = 1'b1; ch_ok = 1'b1;
    tick;
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL loc_early got=%b want=0", tvalid); end
    tick;
    total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL loc_latency got=%b want=1", tvalid); end
    loc_dt = 128'hDEAD; hbad = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (tvalid !== 1'b1 || tdata !== 128'h1234 || loc_ack !== 1'b0) hbad = 1;
    end
    total++; if (hbad) begin bad++; $display("FAIL loc_hold got=tv%b/%h want=tv1/1234", tvalid, tdata); end
    tready = 1'b1; loc_req = 1'b0;
    #1;
    total++; if (loc_ack !== 1'b1 || prop_ack !== 1'b0) begin bad++; $display("FAIL loc_ack got=%b%b want=01", prop_ack, loc_ack); end
    tick;
    total++; if (loc_ack !== 1'b0 || tvalid !== 1'b0) begin bad++; $display("FAIL loc_pulse got=ack%b tv%b want=0/0", loc_ack, tvalid); end
    total++; if (pkt_cnt !== 32'd1) begin bad++; $display("FAIL loc_pkt got=%0d want=1", pkt_cnt); end
    n = 0;
  endtask

  task automatic test_keepalive;
    int           n;
    logic [127:0] exp;
    do_reset;
    id = 8'h05; tready = 1'b1; ch_ok = 1'b1;
    n = 0;
    while (tvalid !== 1'b1 && n < 30) begin tick; n++; end
    total++; if (n != 9) begin bad++; $display("FAIL ka_delay got=%0d want=9", n); end
    exp = {8'hF0, 1'b0, 5'd0, 1'b0, 8'h05, 73'd0, 32'd0};
    total++; if (tdata[127:120] !== 8'hF0) begin bad++; $display("FAIL ka_hdr got=%h want=f0", tdata[127:120]); end
    total++; if (tdata[113:105] !== 9'h005) begin bad++; $display("FAIL ka_id got=%h want=005", tdata[113:105]); end
    total++; if (tdata !== exp) begin bad++; $display("FAIL ka_beat0 got=%h want=%h", tdata, exp); end
    total++; if (prop_ack !== 1'b0 || loc_ack !== 1'b0) begin bad++; $display("FAIL ka_noack got=%b%b want=00", prop_ack, loc_ack); end
    tick; n = 1;
    while (tvalid !== 1'b1 && n < 30) begin tick; n++; end
    total++; if (n != 9) begin bad++; $display("FAIL ka_gap got=%0d want=9", n); end
    total++; if (tdata[31:0] !== 32'd1) begin bad++; $display("FAIL ka_seq got=%0d want=1", tdata[31:0]); end
    tick;
    total++; if (pkt_cnt !== 32'd2) begin bad++; $display("FAIL ka_pkt got=%0d want=2", pkt_cnt); end
  endtask

  task automatic test_ka_collision;
    do_reset;
    tready = 1'b0; ch_ok = 1'b1;
    repeat (8) tick;
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL col_pre got=%b want=0", tvalid); end
    total++; if (dut.r_idle_cnt !== 3'd7) begin bad++; $display("FAIL col_cnt got=%0d want=7", dut.r_idle_cnt); end
    prop_dt = 128'hC0FFEE; prop_req = 1'b1;
    tick;
    total++; if (tvalid !== 1'b1 || tdata !== 128'hC0FFEE) begin bad++; $display("FAIL col_win got=tv%b/%h want=tv1/c0ffee", tvalid, tdata); end
    total++; if (dut.r_idle_cnt !== 3'd0) begin bad++; $display("FAIL col_clr got=%0d want=0", dut.r_idle_cnt); end
    tready = 1'b1; prop_req = 1'b0;
    #1;
    total++; if (prop_ack !== 1'b1) begin bad++; $display("FAIL col_ack got=%b want=1", prop_ack); end
    tick;
    total++; if (dut.r_ka_seq !== 16'd0) begin bad++; $display("FAIL col_noka got=%0d want=0", dut.r_ka_seq); end
  endtask

  task automatic test_chan_drop;
    int n;
    bit hbad;
    do_reset;
    loc_dt = 128'h55; loc_req = 1'b1; ch_ok = 1'b1;
    n = 0;
    while (tvalid !== 1'b1 && n < 10) begin tick; n++; end
    total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL drop_start got=%b want=1", tvalid); end
    ch_ok = 1'b0; loc_req = 1'b0; hbad = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (tvalid !== 1'b1 || rdy !== 1'b1) hbad = 1;
    end
    total++; if (hbad) begin bad++; $display("FAIL drop_hold got=tv%b rdy%b want=1/1", tvalid, rdy); end
    tready = 1'b1;
    #1;
    total++; if (loc_ack !== 1'b1) begin bad++; $display("FAIL drop_ack got=%b want=1", loc_ack); end
    repeat (2) tick;
    total++; if (rdy !== 1'b0 || tvalid !== 1'b0) begin bad++; $display("FAIL drop_nr got=rdy%b tv%b want=0/0", rdy, tvalid); end
  endtask

  task automatic test_reset_mid;
    int n;
    do_reset;
    prop_dt = 128'h1; prop_req = 1'b1; tready = 1'b1; ch_ok = 1'b1;
    n = 0;
    while (prop_ack !== 1'b1 && n < 10) begin tick; n++; end
    tick;
    tready = 1'b0;
    tick;
    total++; if (tvalid !== 1'b1 || pkt_cnt !== 32'd1) begin bad++; $display("FAIL mid_setup got=tv%b pkt%0d want=1/1", tvalid, pkt_cnt); end
    rst = 1'b1; tready = 1'b1;
    #1;
    total++; if (tvalid !== 1'b0 || prop_ack !== 1'b0) begin bad++; $display("FAIL mid_abort got=tv%b ack%b want=0/0", tvalid, prop_ack); end
    total++; if (pkt_cnt !== 32'd0 || rdy !== 1'b0) begin bad++; $display("FAIL mid_clear got=pkt%0d rdy%b want=0/0", pkt_cnt, rdy); end
    tick;
    rst = 1'b0;
    n = 0;
    while (prop_ack !== 1'b1 && n < 10) begin tick; n++; end
    total++; if (prop_ack !== 1'b1) begin bad++; $display("FAIL mid_resume got=%b want=1", prop_ack); end
    prop_req = 1'b0;
    tick;
    total++; if (pkt_cnt !== 32'd1) begin bad++; $display("FAIL mid_pkt got=%0d want=1", pkt_cnt); end
  endtask

  initial begin
    test_reset;
    test_burst;
    test_loc_hold;
    test_keepalive;
    test_ka_collision;
    test_chan_drop;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
